// File: rtl/serial_tx_scheduler.sv
// Purpose: round-robin scheduler sharing one serial transmitter among NUM_REQ word producers.
// Latency: grant is combinational in IDLE; word registered on that edge, tx_data_ready the next cycle.
// Backpressure: one frame in flight; requests wait in IDLE. Build option SCHED_TAG_EN tags tx_data with the source index.
module serial_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 64,
    parameter int FRAME_CYCLES = 66,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_data_ready,
    output logic                      busy,
    output logic [2:0]                cur_chan,
    output logic [15:0]               frame_count
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMAX    = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               take;
    logic [TIMER_W-1:0] timer;
    logic [DATA_W-1:0]  words [NUM_REQ];
    logic [DATA_W-1:0]  cap_word;

    // Unpack the flat request bus into one word per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign words[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Round-robin pick: first set request searching upward from rr_ptr+1.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!pick_vld && req[IDX_W'(idx)]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(idx);
            end
        end
    end

    assign take  = (state == IDLE) && enable && pick_vld;
    // Grant marks the cycle whose closing edge captures the word; held low while in reset.
    assign grant = (take && rst) ? (NUM_REQ'(1) << pick_idx) : '0;

`ifdef SCHED_TAG_EN
    // Top three bits carry the source index so the receiver can demultiplex.
    assign cap_word = {3'(pick_idx), words[pick_idx][DATA_W-4:0]};
`else
    assign cap_word = words[pick_idx];
`endif

    assign tx_data_ready = (state == LOAD);
    assign busy          = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one LOAD cycle, FRAME_CYCLES of WAIT, optional GAP.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = LOAD;
            LOAD:    state_nxt = WAIT;
            WAIT:    if (timer == '0) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (timer == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: word capture on grant, frame/gap timer, completed-frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr      <= IDX_W'(NUM_REQ - 1);
            tx_data     <= '0;
            cur_chan    <= '0;
            frame_count <= '0;
            timer       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        tx_data  <= cap_word;
                        cur_chan <= 3'(pick_idx);
                        rr_ptr   <= pick_idx;
                    end
                end
                LOAD: timer <= TIMER_W'(FRAME_CYCLES - 1);
                WAIT: begin
                    if (timer == '0) begin
                        frame_count <= frame_count + 16'd1;
                        if (GAP_CYCLES > 0) timer <= TIMER_W'(GAP_CYCLES - 1);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                GAP: begin
                    if (timer != '0) timer <= timer - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Purpose: directed self-checking bench for serial_tx_scheduler at default parameters.
// Latency: outputs sampled 3-4 time units after the rising edge; inputs driven there too.
// Backpressure: every wait on the DUT is bounded by a cycle budget.
module tb_serial_tx_scheduler;

    localparam int N = 4;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   grant;
    logic [W-1:0]   tx_data;
    logic           tx_data_ready;
    logic           busy;
    logic [2:0]     cur_chan;
    logic [15:0]    frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    logic [W-1:0] cur_w [N];

    serial_tx_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .req           (req),
        .req_data      (req_data),
        .grant         (grant),
        .tx_data       (tx_data),
        .tx_data_ready (tx_data_ready),
        .busy          (busy),
        .cur_chan      (cur_chan),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int ch, input int seq);
        return {8'hA0, 8'(ch), 16'h0000, 32'(seq)};
    endfunction

    function automatic logic [63:0] exp_word(input int ch, input logic [63:0] w);
`ifdef SCHED_TAG_EN
        logic [2:0] t;
        t = 3'(ch);
        return {t, w[60:0]};
`else
        if (ch < 0) return '0;
        return w;
`endif
    endfunction

    task automatic set_word(input int ch, input logic [63:0] w);
        req_data[ch*W +: W] = w;
        cur_w[ch] = w;
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    // Wait (bounded) until a grant is visible; caller compares the grant value.
    task automatic wait_grant(input int limit);
        int n;
        n = 0;
        #1;
        while (grant == '0 && n < limit) begin
            @(posedge clk);
            #4;
            n++;
        end
    endtask

    // Called at the LOAD sample; counts busy cycles and ready pulses until IDLE.
    task automatic finish_frame(output int bn, output int rn);
        int lim;
        bn  = int'(busy);
        rn  = int'(tx_data_ready);
        lim = 0;
        while (busy && lim < 300) begin
            step();
            lim++;
            bn += int'(busy);
            rn += int'(tx_data_ready);
        end
    endtask

    initial begin
        int bn, rn, prev, seen, ch;
        int exp4 [4];
        exp4 = '{3, 0, 3, 3};

        rst = 1'b0; enable = 1'b0; req = '0; req_data = '0;
        for (int i = 0; i < N; i++) cur_w[i] = '0;
        repeat (3) step();

        // Reset state
        check("rst_grant", 64'(grant), 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_rdy", 64'(tx_data_ready), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_cur_chan", 64'(cur_chan), 0);
        check("rst_frame_count", 64'(frame_count), 0);

        // Request during reset is not granted; first grant after release
        set_word(0, mk(0, 0));
        req = 4'b0001; enable = 1'b1;
        #1;
        check("rst_hold_grant", 64'(grant), 0);
        rst = 1'b1;
        wait_grant(5);
        check("t1_grant", 64'(grant), 64'b0001);
        check("t1_rdy_early", 64'(tx_data_ready), 0);
        step();
        check("t1_rdy", 64'(tx_data_ready), 1);
        check("t1_data", tx_data, exp_word(0, cur_w[0]));
        req = '0;
        repeat (10) step();
        check("t1_busy_wait", 64'(busy), 1);
        check("t1_rdy_wait", 64'(tx_data_ready), 0);

        // Reset mid-WAIT aborts immediately
        rst = 1'b0;
        #1;
        check("t1_abort_busy", 64'(busy), 0);
        check("t1_abort_tx_data", tx_data, 0);
        check("t1_abort_cur_chan", 64'(cur_chan), 0);
        check("t1_abort_frame_count", 64'(frame_count), 0);
        step();
        rst = 1'b1;
        step();

        // Single word from channel 2
        set_word(2, 64'hDEADBEEF_01234567);
        req = 4'b0100;
        wait_grant(5);
        check("t2_grant", 64'(grant), 64'b0100);
        step();
        check("t2_data", tx_data, exp_word(2, 64'hDEADBEEF_01234567));
        check("t2_cur_chan", 64'(cur_chan), 2);
        check("t2_rdy", 64'(tx_data_ready), 1);
        req = '0;
        finish_frame(bn, rn);
        check("t2_busy_cycles", 64'(bn), 69);
        check("t2_rdy_pulses", 64'(rn), 1);
        check("t2_frame_count", 64'(frame_count), 1);
        check("t2_data_hold", tx_data, exp_word(2, 64'hDEADBEEF_01234567));

        // Round robin with all requesters active
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_word(i, mk(i, 0));
        req  = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            ch = k % N;
            wait_grant(100);
            check("t3_grant", 64'(grant), 64'(1) << ch);
            if (k > 0) check("t3_spacing", 64'(cyc_cnt - prev), 70);
            prev = cyc_cnt;
            step();
            check("t3_data", tx_data, exp_word(ch, cur_w[ch]));
            check("t3_cur_chan", 64'(cur_chan), 64'(ch));
            set_word(ch, mk(ch, k + 1));
            if (k == 4) req = '0;
            finish_frame(bn, rn);
            check("t3_busy_cycles", 64'(bn), 69);
            if (k == 3) check("t3_frame_count", 64'(frame_count), 4);
        end

        // Skip and rotate between channels 0 and 3
        req = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            wait_grant(100);
            check("t4_grant", 64'(grant), 64'(1) << exp4[k]);
            step();
            check("t4_cur_chan", 64'(cur_chan), 64'(exp4[k]));
            if (k == 2) req = 4'b1000;
            if (k == 3) req = '0;
            finish_frame(bn, rn);
        end
        check("t4_frame_count", 64'(frame_count), 9);

        // Enable dropped mid-frame: frame completes, then scheduling holds
        set_word(1, 64'hFFFF_FFFF_FFFF_FFFF);
        req = 4'b1111;
        wait_grant(5);
        check("t5_grant", 64'(grant), 64'b0001);
        step();
        repeat (10) step();
        enable = 1'b0;
        finish_frame(bn, rn);
        check("t5_remaining_busy", 64'(bn), 59);
        check("t5_frame_count", 64'(frame_count), 10);
        seen = 0;
        repeat (20) begin
            step();
            if (grant != '0 || busy) seen++;
        end
        check("t5_hold_idle", 64'(seen), 0);
        enable = 1'b1;
        wait_grant(5);
        check("t5_resume_grant", 64'(grant), 64'b0010);
        step();
        check("t5_cur_chan", 64'(cur_chan), 1);
        check("t5_data_ones", tx_data, exp_word(1, 64'hFFFF_FFFF_FFFF_FFFF));
        req = '0;
        finish_frame(bn, rn);
        check("t5_rdy_pulses", 64'(rn), 1);
        check("t5_frame_count_end", 64'(frame_count), 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_tx_scheduler.md
Name: serial_tx_scheduler

Overview:
Round-robin scheduler that shares one serial transmitter between NUM_REQ 64-bit word producers, such as readout channels.
- Grants one requester at a time and presents its word on tx_data with a one-cycle tx_data_ready pulse.
- Times the transmitter's frame locally, so at most one word is ever outstanding in the transmitter buffer.
- Sits between the channel word sources and the serial transmitter.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 64, word width per requester
FRAME_CYCLES, 66, transmitter clocks per word (start bit + 64 data + idle)
GAP_CYCLES, 2, idle clocks inserted between consecutive frames (0 allowed)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
enable  input  1  1 = scheduling allowed; 0 = finish current frame then hold in IDLE
req  input  NUM_REQ  per-requester word-valid, level, held until granted
req_data  input  NUM_REQ*DATA_W  packed words, requester i at bits [i*DATA_W +: DATA_W]
grant  output  NUM_REQ  one-hot, one-cycle pulse: requester's word captured this cycle
tx_data  output  DATA_W  word to transmitter, registered, stable from the load cycle to the end of the frame
tx_data_ready  output  1  one-cycle pulse to the transmitter data_ready
busy  output  1  1 while in LOAD, WAIT or GAP
cur_chan  output  3  index of the requester whose frame is in flight
frame_count  output  16  frames sent since reset, wraps 0xFFFF->0

Behaviour:
Reset (rst=0, async) forces the following; reset mid-frame aborts scheduling immediately.
- state=IDLE, rr_ptr=NUM_REQ-1.
- grant=0, tx_data=0, tx_data_ready=0, busy=0, cur_chan=0, frame_count=0, timer=0.

FSM states: IDLE, LOAD, WAIT, GAP.

IDLE:
- If enable=1 and |req, the arbiter picks the first set req[i] searching from rr_ptr+1 upward, modulo NUM_REQ.
- On that same edge: tx_data<=req_data[i], cur_chan<=i, rr_ptr<=i, grant[i] pulses for 1 cycle, go to LOAD.

LOAD (1 cycle):
- tx_data_ready=1 for exactly this cycle.
- timer<=FRAME_CYCLES-1, go to WAIT.

WAIT:
- timer decrements each clock.
- When timer==0: frame_count<=frame_count+1.
- Then go to GAP if GAP_CYCLES>0 (timer<=GAP_CYCLES-1), else IDLE.

GAP:
- timer decrements; at 0 go to IDLE.

Timing and handshake rules:
- Grant-to-grant spacing with continuous requests is exactly 1+FRAME_CYCLES+GAP_CYCLES+1 clocks (70 at defaults).
- tx_data_ready pulses once per frame, never while busy=1 outside LOAD.
- req/req_data are sampled only in IDLE. A requester deasserts req, or presents its next word, in the cycle after its grant pulse.
- A requester dropping req before it is granted is simply skipped; no error.
- A lone requester re-wins every frame.
- All requesters asserted gives order rr_ptr+1, +2, ... with no starvation.
- enable falling during LOAD, WAIT or GAP does not truncate the frame; the FSM stops in IDLE afterwards.
- tx_data holds its value after the frame; it is only updated on a grant.
- frame_count increments on frame completion, not on grant.

Optional Feature:
Macro: SCHED_TAG_EN.
- Defined: tx_data[DATA_W-1 -: 3] is replaced by the granted requester index at capture, so the receiver can identify the source. Requester bits [DATA_W-1:DATA_W-3] are discarded.
- Undefined: tx_data is the requester word unmodified.
- Timing, grant and frame counting are identical in both builds.

Test Plan:
1. Reset: rst=0 mid-WAIT -> next sample shows all outputs 0 and state IDLE; rst=1 with req=4'b0001 -> grant=4'b0001 on the first edge, tx_data_ready one cycle later.
2. Single word: req[2]=1, req_data word2=64'hDEADBEEF_01234567 -> grant=4'b0100, tx_data=64'hDEADBEEF_01234567, cur_chan=2, tx_data_ready high 1 cycle. busy high 1+66+2=69 cycles, then frame_count=1.
3. Round robin: req=4'b1111 held, each requester updating its word after grant -> grant order 0,1,2,3,0; grants 70 clocks apart; frame_count=4 after the 4th frame.
4. Skip/rotate: req=4'b1001 after channel 3 wins -> next grant channel 0, then 3, alternating; req[0] dropped before its turn -> channel 3 granted again.
5. Enable: enable=0 at cycle 10 of WAIT -> frame completes (frame_count+1); no further grant while req=4'b1111; enable=1 -> grant resumes at rr_ptr+1.
6. SCHED_TAG_EN build: channel 5 (NUM_REQ=8) word 64'hFFFF_FFFF_FFFF_FFFF -> tx_data=64'hBFFF_FFFF_FFFF_FFFF. Non-tag build -> tx_data unchanged.
